wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback path and a multi-cycle unit (MCU, e.g. multiply/divide) that returns results out of band. MCU results are buffered in a small FIFO and granted in pipeline idle slots. An optional starvation guard forces a one-cycle pipeline stall to drain waiting MCU results. Sits after the writeback mux, directly in front of the register-file write port.

---
 rtl/wb_arb_pkg.sv | 19 +
 rtl/wb_arb_fifo.sv | 73 +++++++
 rtl/wb_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_MCU
  } gnt_src_e;

endpackage

// File: rtl/wb_arb_fifo.sv
// DEPTH-entry synchronous FIFO of MCU writeback requests with full/empty flags.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t wr_req,
  output wb_req_t rd_req,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_req  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_req;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and buffered MCU results.
// Define WB_ARB_STARVE_EN to add the starvation guard (wait counter + one-cycle stall_pipe).
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite_WB,
  input  logic [REG_ADDR_W-1:0] rd_WB,
  input  logic [DATA_W-1:0]     write_data_WB,
  input  logic                  mc_valid,
  input  logic [REG_ADDR_W-1:0] mc_rd,
  input  logic [DATA_W-1:0]     mc_data,
  output logic                  mc_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  stall_pipe,
  output logic [NUM_REGS-1:0]   pending_mask
);

  if (!(DEPTH == 2 || DEPTH == 4)) begin : g_bad_depth
    $error("wb_port_arbiter: DEPTH must be 2 or 4");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("wb_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  wb_req_t               mc_req, head;
  logic                  fifo_full, fifo_empty, push, pop, stall_cur;
  gnt_src_e              gnt_src;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  assign mc_req   = '{rd: mc_rd, data: mc_data};
  assign mc_ready = !fifo_full;
  assign push     = mc_valid && !fifo_full;

  wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wr_req (mc_req),
    .rd_req (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    gnt_src = GNT_NONE;
    if (stall_cur) begin
      gnt_src = fifo_empty ? GNT_NONE : GNT_MCU;
    end else if (RegWrite_WB) begin
      gnt_src = GNT_PIPE;
    end else if (!fifo_empty) begin
      gnt_src = GNT_MCU;
    end
  end

  assign pop = (gnt_src == GNT_MCU);

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;
    case (gnt_src)
      GNT_PIPE: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = rd_WB;
        rf_wdata_d = write_data_WB;
      end
      GNT_MCU: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = head.rd;
        rf_wdata_d = head.data;
      end
      default: ;
    endcase
    // A same-cycle push to the popped rd must leave its bit set, so set after clear.
    pending_d = pending_q;
    if (pop)  pending_d[head.rd] = 1'b0;
    if (push) pending_d[mc_rd]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pending_q  <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign pending_mask = pending_q;

`ifdef WB_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt_q, cnt_d;
  logic       stall_q, stall_d;

  // Counter saturates so a blocked head never wraps back below the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (fifo_empty || pop) begin
      cnt_d = '0;
    end else if (cnt_q != 4'hF) begin
      cnt_d = cnt_q + 4'd1;
    end
    stall_d = !stall_q && !fifo_empty && !pop && (cnt_q == LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cur  = stall_q;
  assign stall_pipe = stall_q;
`else
  assign stall_cur  = 1'b0;
  assign stall_pipe = 1'b0;
`endif

`ifndef SYNTHESIS
  // Decode must hold back any pipeline write to a register with an MCU result in flight.
  always_ff @(posedge clk) begin
    if (!reset && RegWrite_WB) begin
      assert (!pending_q[rd_WB])
        else $error("wb_port_arbiter: pipeline write to pending rd %0d", rd_WB);
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       RegWrite_WB;
  logic [2:0] rd_WB;
  logic [7:0] write_data_WB;
  logic       mc_valid;
  logic [2:0] mc_rd;
  logic [7:0] mc_data;
  logic       mc_ready;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       stall_pipe;
  logic [7:0] pending_mask;

  int n_tests = 0;
  int n_fail  = 0;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite_WB   (RegWrite_WB),
    .rd_WB         (rd_WB),
    .write_data_WB (write_data_WB),
    .mc_valid      (mc_valid),
    .mc_rd         (mc_rd),
    .mc_data       (mc_data),
    .mc_ready      (mc_ready),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .stall_pipe    (stall_pipe),
    .pending_mask  (pending_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [2:0] addr,
                          input logic [7:0] data, input bit check_all);
    n_tests++;
    assert (rf_we === we) else begin
      n_fail++;
      $error("FAIL %s rf_we observed=%0b expected=%0b", tag, rf_we, we);
    end
    if (we || check_all) begin
      n_tests++;
      assert (rf_waddr === addr) else begin
        n_fail++;
        $error("FAIL %s rf_waddr observed=%0d expected=%0d", tag, rf_waddr, addr);
      end
      n_tests++;
      assert (rf_wdata === data) else begin
        n_fail++;
        $error("FAIL %s rf_wdata observed=%02h expected=%02h", tag, rf_wdata, data);
      end
    end
  endtask

  task automatic check_ctl(input string tag, input logic stall, input logic [7:0] pend,
                           input logic ready);
    n_tests++;
    assert (stall_pipe === stall) else begin
      n_fail++;
      $error("FAIL %s stall_pipe observed=%0b expected=%0b", tag, stall_pipe, stall);
    end
    n_tests++;
    assert (pending_mask === pend) else begin
      n_fail++;
      $error("FAIL %s pending_mask observed=%02h expected=%02h", tag, pending_mask, pend);
    end
    n_tests++;
    assert (mc_ready === ready) else begin
      n_fail++;
      $error("FAIL %s mc_ready observed=%0b expected=%0b", tag, mc_ready, ready);
    end
  endtask

  initial begin
    logic [7:0] sdat [8];
    sdat = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h36};

    reset = 1'b1; RegWrite_WB = 1'b0; rd_WB = '0; write_data_WB = '0;
    mc_valid = 1'b0; mc_rd = '0; mc_data = '0;
    tick(); tick();
    reset = 1'b0;
    check_rf("reset", 1'b0, 3'd0, 8'h00, 1'b1);
    check_ctl("reset", 1'b0, 8'h00, 1'b1);
    tick();
    check_rf("idle", 1'b0, 3'd0, 8'h00, 1'b0);

    // Pipeline-only write.
    RegWrite_WB = 1'b1; rd_WB = 3'd3; write_data_WB = 8'h5A;
    tick();
    check_rf("pipe_wr", 1'b1, 3'd3, 8'h5A, 1'b0);
    RegWrite_WB = 1'b0;
    tick();
    check_rf("pipe_idle", 1'b0, 3'd0, 8'h00, 1'b0);

    // MCU result in an idle slot.
    mc_valid = 1'b1; mc_rd = 3'd5; mc_data = 8'h11;
    tick();
    mc_valid = 1'b0;
    check_rf("mcu_nobypass", 1'b0, 3'd0, 8'h00, 1'b0);
    check_ctl("mcu_pending", 1'b0, 8'h20, 1'b1);
    tick();
    check_rf("mcu_wr", 1'b1, 3'd5, 8'h11, 1'b0);
    check_ctl("mcu_cleared", 1'b0, 8'h00, 1'b1);
    tick();
    check_rf("mcu_done", 1'b0, 3'd0, 8'h00, 1'b0);

    // FIFO fills while the pipeline owns the port.
    RegWrite_WB = 1'b1; rd_WB = 3'd1; write_data_WB = 8'h01;
    mc_valid = 1'b1; mc_rd = 3'd6; mc_data = 8'hA1;
    tick();
    check_rf("full_p1", 1'b1, 3'd1, 8'h01, 1'b0);
    check_ctl("full_push1", 1'b0, 8'h40, 1'b1);
    rd_WB = 3'd2; write_data_WB = 8'h02; mc_rd = 3'd7; mc_data = 8'hA2;
    tick();
    check_rf("full_p2", 1'b1, 3'd2, 8'h02, 1'b0);
    rd_WB = 3'd3; write_data_WB = 8'h03; mc_rd = 3'd4; mc_data = 8'hA3;
    #1;
    check_ctl("full_flag", 1'b0, 8'hC0, 1'b0);
    tick();
    check_rf("full_p3", 1'b1, 3'd3, 8'h03, 1'b0);
    check_ctl("full_reject", 1'b0, 8'hC0, 1'b0);
    RegWrite_WB = 1'b0; mc_valid = 1'b0;
    tick();
    check_rf("drain1", 1'b1, 3'd6, 8'hA1, 1'b0);
    check_ctl("drain1", 1'b0, 8'h80, 1'b1);
    tick();
    check_rf("drain2", 1'b1, 3'd7, 8'hA2, 1'b0);
    check_ctl("drain2", 1'b0, 8'h00, 1'b1);
    tick();
    check_rf("drain_done", 1'b0, 3'd0, 8'h00, 1'b0);

    // Pipeline writes every cycle with one MCU entry buffered.
    RegWrite_WB = 1'b1; rd_WB = 3'd2;
    for (int k = 0; k < 8; k++) begin
      write_data_WB = sdat[k];
      mc_valid = (k == 0); mc_rd = 3'd5; mc_data = 8'h77;
      tick();
`ifdef WB_ARB_STARVE_EN
      if (k == 6) begin
        check_rf("starve_mcu", 1'b1, 3'd5, 8'h77, 1'b0);
        check_ctl("starve_mcu", 1'b0, 8'h00, 1'b1);
      end else begin
        check_rf("starve_pipe", 1'b1, 3'd2, sdat[k], 1'b0);
        check_ctl("starve_pipe", (k == 5), (k < 6) ? 8'h20 : 8'h00, 1'b1);
      end
`else
      check_rf("strict_pipe", 1'b1, 3'd2, sdat[k], 1'b0);
      check_ctl("strict_pipe", 1'b0, 8'h20, 1'b1);
`endif
    end
    mc_valid = 1'b0; RegWrite_WB = 1'b0;
    tick();
`ifdef WB_ARB_STARVE_EN
    check_rf("starve_after", 1'b0, 3'd0, 8'h00, 1'b0);
`else
    check_rf("strict_mcu", 1'b1, 3'd5, 8'h77, 1'b0);
`endif
    check_ctl("starve_end", 1'b0, 8'h00, 1'b1);

    // Reset with two entries buffered.
    RegWrite_WB = 1'b1; rd_WB = 3'd1; write_data_WB = 8'h0F;
    mc_valid = 1'b1; mc_rd = 3'd3; mc_data = 8'hB1;
    tick();
    mc_rd = 3'd4; mc_data = 8'hB2;
    tick();
    check_ctl("pre_reset", 1'b0, 8'h18, 1'b0);
    reset = 1'b1; RegWrite_WB = 1'b0; mc_valid = 1'b0;
    tick();
    reset = 1'b0;
    check_rf("mid_reset", 1'b0, 3'd0, 8'h00, 1'b1);
    check_ctl("mid_reset", 1'b0, 8'h00, 1'b1);
    tick();
    check_rf("post_reset", 1'b0, 3'd0, 8'h00, 1'b0);
    check_ctl("post_reset", 1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
